// File: rtl/sw_fifo_egress_sched.sv
// sw_fifo_egress_sched: round-robin scheduler draining per-switch FIFOs onto one egress link
// Ports: clk, rst_n (sync, active-low); sw_busy/empty_in/full_in per-FIFO status;
//   rd_data_in packed FIFO read data; ready_in downstream accept; rd_fifo one-hot read strobe;
//   valid_out/data_out/fifo_idx_out egress word; sched_busy high outside IDLE.
// Optional: SW_FIFO_FULL_PRIORITY_EN gives full FIFOs precedence within the round-robin scan.
module sw_fifo_egress_sched #(
  parameter int NUM_SW_INST = 5,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH = $clog2(NUM_SW_INST)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SW_INST-1:0]            sw_busy,
  input  logic [NUM_SW_INST-1:0]            empty_in,
  input  logic [NUM_SW_INST-1:0]            full_in,
  input  logic [NUM_SW_INST*DATA_WIDTH-1:0] rd_data_in,
  input  logic                              ready_in,
  output logic [NUM_SW_INST-1:0]            rd_fifo,
  output logic                              valid_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic [IDX_WIDTH-1:0]              fifo_idx_out,
  output logic                              sched_busy
);
  typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;
  state_t state, nxt;
  logic [IDX_WIDTH-1:0] ptr, grant_idx, sel, j;
  logic [DATA_WIDTH-1:0] data_ff;
  logic [NUM_SW_INST-1:0] elig, cand;
  logic any;
`ifndef SW_FIFO_FULL_PRIORITY_EN
  logic unused_full;
  assign unused_full = ^full_in;
`endif
  always_comb begin
    elig = ~empty_in & ~sw_busy;
`ifdef SW_FIFO_FULL_PRIORITY_EN
    cand = |(elig & full_in) ? elig & full_in : elig;
`else
    cand = elig;
`endif
    any = |cand;
    sel = '0;
    j = '0;
    // scan from farthest to nearest so the closest candidate after ptr wins
    for (int k = NUM_SW_INST - 1; k >= 0; k--) begin
      j = IDX_WIDTH'((int'(ptr) + k) % NUM_SW_INST);
      if (cand[j]) sel = j;
    end
  end
  always_comb begin
    nxt = state == IDLE ? (any ? RD : IDLE) :
          state == RD   ? CAP :
          state == CAP  ? SEND :
          ready_in      ? IDLE : SEND;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      data_ff   <= '0;
      rd_fifo   <= '0;
    end else begin
      state   <= nxt;
      rd_fifo <= (state == IDLE && any) ? NUM_SW_INST'(1) << sel : '0;
      if (state == IDLE && any) grant_idx <= sel;
      if (state == CAP) data_ff <= rd_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      if (state == SEND && ready_in)
        ptr <= (grant_idx == IDX_WIDTH'(NUM_SW_INST - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
  assign valid_out    = state == SEND;
  assign data_out     = data_ff;
  assign fifo_idx_out = grant_idx;
  assign sched_busy   = state != IDLE;
endmodule

// File: tb/tb_sw_fifo_egress_sched.sv
// tb_sw_fifo_egress_sched: table-driven and directed checks of the egress scheduler with a data scoreboard
module tb_sw_fifo_egress_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [4:0] sw_busy, empty_in, full_in, rd_fifo;
  logic ready_in, valid_out, sched_busy;
  logic [159:0] rd_data_in;
  logic [31:0] data_out;
  logic [2:0] fifo_idx_out;
  int tag = 0;
  logic dead = 1'b0;
  int pass_n = 0, total_n = 0;
  localparam logic [4:0] Z = 5'b00000, F = 5'b11111;
`ifdef SW_FIFO_FULL_PRIORITY_EN
  localparam logic [4:0] FP_RD = 5'b01000;
  localparam logic [2:0] FP_I = 3'd3;
`else
  localparam logic [4:0] FP_RD = 5'b00001;
  localparam logic [2:0] FP_I = 3'd0;
`endif
  typedef struct {logic [2:0] idx; logic [31:0] data;} exp_t;
  typedef struct {
    logic r; logic [4:0] e, b, f; logic rdy;
    logic [4:0] xr; logic xv; logic [2:0] xi; logic xb;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  sw_fifo_egress_sched dut (
    .clk(clk), .rst_n(rst_n), .sw_busy(sw_busy), .empty_in(empty_in), .full_in(full_in),
    .rd_data_in(rd_data_in), .ready_in(ready_in), .rd_fifo(rd_fifo), .valid_out(valid_out),
    .data_out(data_out), .fifo_idx_out(fifo_idx_out), .sched_busy(sched_busy)
  );
  always_comb
    for (int i = 0; i < 5; i++)
      rd_data_in[i*32 +: 32] = dead ? 32'hDEADBEEF : {tag[23:0], 8'(i)};
  function automatic vec_t mk(logic r, logic [4:0] e, logic [4:0] b, logic [4:0] f, logic rdy,
                              logic [4:0] xr, logic xv, logic [2:0] xi, logic xb);
    vec_t t;
    t.r = r; t.e = e; t.b = b; t.f = f; t.rdy = rdy;
    t.xr = xr; t.xv = xv; t.xi = xi; t.xb = xb;
    return t;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    total_n++;
    if (a === x) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", n, a, x);
  endtask
  task automatic push(logic [2:0] i, logic [31:0] d);
    exp_t x;
    x.idx = i; x.data = d;
    sb.push_back(x);
  endtask
  task automatic push_tag(logic [2:0] i);
    push(i, {24'(tag + 2), 8'(i)});
  endtask
  task automatic step(logic r, logic [4:0] e, logic [4:0] b, logic [4:0] f, logic rdy);
    tag++;
    rst_n = r; empty_in = e; sw_busy = b; full_in = f; ready_in = rdy;
    if (r && valid_out && rdy) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_data_out", data_out, x.data);
        chk("sb_fifo_idx_out", 32'(fifo_idx_out), 32'(x.idx));
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    sw_busy = Z; empty_in = F; full_in = Z; ready_in = 1'b0;
    tbl.push_back(mk(1'b0, F, Z, Z, 1'b1, Z, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, Z, Z, Z, 1'b1, Z, 1'b0, 3'd0, 1'b0));
    for (int g = 0; g < 6; g++) begin
      automatic logic [2:0] i = 3'(g % 5);
      tbl.push_back(mk(1'b1, Z, Z, Z, 1'b1, 5'b00001 << i, 1'b0, i, 1'b1));
      tbl.push_back(mk(1'b1, Z, Z, Z, 1'b1, Z, 1'b0, i, 1'b1));
      tbl.push_back(mk(1'b1, Z, Z, Z, 1'b1, Z, 1'b1, i, 1'b1));
      tbl.push_back(mk(1'b1, Z, Z, Z, 1'b1, Z, 1'b0, i, 1'b0));
    end
    tbl.push_back(mk(1'b0, 5'b11011, Z, Z, 1'b1, Z, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b11011, Z, Z, 1'b1, 5'b00100, 1'b0, 3'd2, 1'b1));
    tbl.push_back(mk(1'b1, 5'b11011, Z, Z, 1'b1, Z, 1'b0, 3'd2, 1'b1));
    tbl.push_back(mk(1'b1, 5'b11011, Z, Z, 1'b1, Z, 1'b1, 3'd2, 1'b1));
    tbl.push_back(mk(1'b1, F, Z, Z, 1'b1, Z, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b11110, Z, Z, 1'b1, 5'b00001, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(1'b1, 5'b11110, Z, Z, 1'b1, Z, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(1'b1, 5'b11110, Z, Z, 1'b1, Z, 1'b1, 3'd0, 1'b1));
    tbl.push_back(mk(1'b1, F, Z, Z, 1'b1, Z, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, Z, 5'b00010, Z, 1'b1, 5'b00100, 1'b0, 3'd2, 1'b1));
    tbl.push_back(mk(1'b1, Z, 5'b00110, Z, 1'b1, Z, 1'b0, 3'd2, 1'b1));
    tbl.push_back(mk(1'b1, Z, 5'b00110, Z, 1'b1, Z, 1'b1, 3'd2, 1'b1));
    tbl.push_back(mk(1'b1, Z, 5'b00110, Z, 1'b1, Z, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(1'b1, F, Z, Z, 1'b1, Z, 1'b0, 3'd0, 1'b0));
    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].e, tbl[k].b, tbl[k].f, tbl[k].rdy);
      chk($sformatf("rd_fifo[%0d]", k), 32'(rd_fifo), 32'(tbl[k].xr));
      chk($sformatf("valid_out[%0d]", k), 32'(valid_out), 32'(tbl[k].xv));
      chk($sformatf("sched_busy[%0d]", k), 32'(sched_busy), 32'(tbl[k].xb));
      if (tbl[k].xv) chk($sformatf("fifo_idx_out[%0d]", k), 32'(fifo_idx_out), 32'(tbl[k].xi));
      if (!tbl[k].r) chk($sformatf("data_out_rst[%0d]", k), data_out, 32'd0);
      if (tbl[k].xr != Z) push_tag(tbl[k].xi);
    end
    dead = 1'b1;
    step(1'b1, 5'b11110, Z, Z, 1'b0);
    chk("hold_rd", 32'(rd_fifo), 32'h1);
    push(3'd0, 32'hDEADBEEF);
    step(1'b1, F, Z, Z, 1'b0);
    step(1'b1, F, Z, Z, 1'b0);
    chk("hold_send", 32'(valid_out), 32'd1);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, F, Z, Z, 1'b0);
      chk($sformatf("hold_valid[%0d]", c), 32'(valid_out), 32'd1);
      chk($sformatf("hold_data[%0d]", c), data_out, 32'hDEADBEEF);
      chk($sformatf("hold_idx[%0d]", c), 32'(fifo_idx_out), 32'd0);
      chk($sformatf("hold_no_rd[%0d]", c), 32'(rd_fifo), 32'd0);
    end
    dead = 1'b0;
    step(1'b1, F, Z, Z, 1'b1);
    chk("hold_accept_valid", 32'(valid_out), 32'd0);
    chk("hold_accept_idle", 32'(sched_busy), 32'd0);
    step(1'b1, Z, Z, Z, 1'b0);
    chk("cap_rst_rd", 32'(rd_fifo), 32'h2);
    step(1'b1, Z, Z, Z, 1'b1);
    chk("cap_rst_incap", 32'(sched_busy), 32'd1);
    chk("cap_rst_incap_valid", 32'(valid_out), 32'd0);
    step(1'b0, Z, Z, Z, 1'b1);
    chk("cap_rst_valid", 32'(valid_out), 32'd0);
    chk("cap_rst_rdz", 32'(rd_fifo), 32'd0);
    chk("cap_rst_busy", 32'(sched_busy), 32'd0);
    chk("cap_rst_data", data_out, 32'd0);
    chk("cap_rst_idx", 32'(fifo_idx_out), 32'd0);
    step(1'b1, Z, Z, Z, 1'b1);
    chk("cap_rst_regrant", 32'(rd_fifo), 32'h1);
    push_tag(3'd0);
    step(1'b1, Z, Z, Z, 1'b1);
    step(1'b1, Z, Z, Z, 1'b1);
    chk("cap_rst_send_idx", 32'(fifo_idx_out), 32'd0);
    chk("cap_rst_send_valid", 32'(valid_out), 32'd1);
    step(1'b1, F, Z, Z, 1'b1);
    chk("cap_rst_done", 32'(sched_busy), 32'd0);
    step(1'b0, F, Z, Z, 1'b1);
    step(1'b1, Z, Z, 5'b01000, 1'b1);
    chk("full_prio_rd", 32'(rd_fifo), 32'(FP_RD));
    push_tag(FP_I);
    step(1'b1, F, Z, Z, 1'b1);
    step(1'b1, F, Z, Z, 1'b1);
    chk("full_prio_idx", 32'(fifo_idx_out), 32'(FP_I));
    step(1'b1, F, Z, Z, 1'b1);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
